// File: rtl/makehint_pack_if.sv
// Handshake bundle for makehint_pack: input coefficient beats and the packed output word stream.
// Both directions: a transfer happens on a clock edge where valid and ready are both high; valid never waits on ready.
interface makehint_pack_if #(
    parameter int OUTPUT_W = 4,
    parameter int COEFF_W  = 24,
    parameter int W        = 64
);
    logic [OUTPUT_W*COEFF_W-1:0] poly0_i;
    logic [OUTPUT_W*COEFF_W-1:0] poly1_i;
    logic                        poly_valid_i;
    logic                        poly_ready_i;
    logic [W-1:0]                do_o;
    logic                        valid_o;
    logic                        ready_o;

    modport master (
        output poly0_i, poly1_i, poly_valid_i, ready_o,
        input  poly_ready_i, do_o, valid_o
    );

    modport slave (
        input  poly0_i, poly1_i, poly_valid_i, ready_o,
        output poly_ready_i, do_o, valid_o
    );
endinterface

// File: rtl/makehint_pack.sv
// Dilithium MakeHint encoder: collects hint positions/counts and emits the packed hint field as 64-bit words.
// Define MAKEHINT_COMPUTE_EN to evaluate MakeHint from r0/r1; otherwise lane bit 0 of poly0_i is the hint.
module makehint_pack #(
    parameter int OUTPUT_W = 4,
    parameter int COEFF_W  = 24,
    parameter int W        = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       sec_lvl,
    makehint_pack_if.slave   bus,
    output logic             done,
    output logic             reject,
    output logic [2:0]       state_dbg_o
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_COLLECT = 3'd2,
        S_EMIT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     state_q;
    logic [8:0] beat_q;
    logic [7:0] cnt_q;
    logic [3:0] word_q;
    logic       rdy_q, valid_q, done_q, rej_q;
    logic [7:0] slot_q  [0:79];
    logic [7:0] count_q [0:7];

    logic [2:0]  km1;
    logic [3:0]  k_lvl;
    logic [6:0]  omega;
    logic [23:0] gamma2, q_m_g2;
    logic [3:0]  last_word;
    logic [8:0]  last_beat;

    always_comb begin
        case (sec_lvl)
            3'd2: begin km1 = 3'd3; omega = 7'd80; gamma2 = 24'd95232;  q_m_g2 = 24'd8285185; last_word = 4'd10; end
            3'd3: begin km1 = 3'd5; omega = 7'd55; gamma2 = 24'd261888; q_m_g2 = 24'd8118529; last_word = 4'd7;  end
            default: begin km1 = 3'd7; omega = 7'd75; gamma2 = 24'd261888; q_m_g2 = 24'd8118529; last_word = 4'd10; end
        endcase
        k_lvl     = {1'b0, km1} + 4'd1;
        last_beat = {km1, 6'h3f};
    end

    logic [OUTPUT_W-1:0] hbit;
    always_comb begin
        hbit = '0;
        for (int i = 0; i < OUTPUT_W; i++) begin
`ifdef MAKEHINT_COMPUTE_EN
            hbit[i] = ((bus.poly0_i[i*COEFF_W +: COEFF_W] > gamma2) &&
                       (bus.poly0_i[i*COEFF_W +: COEFF_W] < q_m_g2)) ||
                      ((bus.poly0_i[i*COEFF_W +: COEFF_W] == q_m_g2) &&
                       (bus.poly1_i[i*COEFF_W +: COEFF_W] != '0));
`else
            hbit[i] = bus.poly0_i[i*COEFF_W];
`endif
        end
    end

    // Slot position of each lane within the beat; a hint landing at or past omega rejects.
    logic [7:0] pos [OUTPUT_W];
    logic [7:0] run_c, cnt_next;
    logic       over;
    always_comb begin
        run_c = cnt_q;
        over  = 1'b0;
        for (int i = 0; i < OUTPUT_W; i++) begin
            pos[i] = run_c;
            if (hbit[i]) begin
                if (run_c >= {1'b0, omega}) over = 1'b1;
                run_c = run_c + 8'd1;
            end
        end
        cnt_next = run_c;
    end

    // Stream byte b: slots below omega, then K count bytes, then zero padding.
    logic [W-1:0] emit_word;
    logic [6:0]   b_c;
    logic [7:0]   end_c;
    logic [6:0]   cidx_c;
    always_comb begin
        emit_word = '0;
        b_c       = '0;
        cidx_c    = '0;
        end_c     = {1'b0, omega} + {4'b0, k_lvl};
        for (int k = 0; k < 8; k++) begin
            b_c    = {word_q[3:0], k[2:0]};
            cidx_c = b_c - omega;
            if (b_c < omega)
                emit_word[W-1-8*k -: 8] = slot_q[b_c];
            else if ({1'b0, b_c} < end_c)
                emit_word[W-1-8*k -: 8] = count_q[cidx_c[2:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            rdy_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_CLEAR;
                end
                S_CLEAR: begin
                    for (int s = 0; s < 80; s++) slot_q[s] <= '0;
                    for (int c = 0; c < 8; c++) count_q[c] <= '0;
                    cnt_q   <= '0;
                    rej_q   <= 1'b0;
                    beat_q  <= '0;
                    word_q  <= '0;
                    rdy_q   <= 1'b1;
                    state_q <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (bus.poly_valid_i) begin
                        if (!rej_q) begin
                            for (int i = 0; i < OUTPUT_W; i++)
                                if (hbit[i] && (pos[i] < {1'b0, omega}))
                                    slot_q[pos[i][6:0]] <= {beat_q[5:0], i[1:0]};
                            cnt_q <= cnt_next;
                        end
                        rej_q <= rej_q | over;
                        if (beat_q[5:0] == 6'h3f) count_q[beat_q[8:6]] <= cnt_next;
                        beat_q <= beat_q + 9'd1;
                        if (beat_q == last_beat) begin
                            rdy_q <= 1'b0;
                            if (rej_q | over) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                valid_q <= 1'b1;
                                state_q <= S_EMIT;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    if (bus.ready_o) begin
                        if (word_q == last_word) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            word_q <= word_q + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The word is a pure function of held registers, so it stays stable while ready_o is low.
    assign bus.do_o         = valid_q ? emit_word : '0;
    assign bus.valid_o      = valid_q;
    assign bus.poly_ready_i = rdy_q;
    assign done             = done_q;
    assign reject           = rej_q;
    assign state_dbg_o      = state_q;
endmodule

// File: tb/tb_makehint_pack.sv
// Directed bench for makehint_pack: hand-computed word streams, boundary lanes, reject, stalls and mid-emit reset.
module tb_makehint_pack;
    localparam int W = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] sec_lvl;
    logic       done;
    logic       reject;
    logic [2:0] state_dbg;

    makehint_pack_if bus ();

    makehint_pack dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sec_lvl     (sec_lvl),
        .bus         (bus.slave),
        .done        (done),
        .reject      (reject),
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [23:0] r0_mem [0:2047];
    logic [23:0] r1_mem [0:2047];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) begin
            r0_mem[i] = '0;
            r1_mem[i] = '0;
        end
    endtask

    task automatic drive_beat(input int beat);
        for (int i = 0; i < 4; i++) begin
            bus.poly0_i[i*24 +: 24] = r0_mem[beat*4 + i];
            bus.poly1_i[i*24 +: 24] = r1_mem[beat*4 + i];
        end
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('0);
    endtask

    // abort_after > 0: assert rst after that many words have been accepted.
    task automatic run_encode(input logic [2:0] lvl, input int k, input int nwords,
                              input bit exp_rej, input bit rand_hs, input int abort_after);
        int beat;
        int budget;
        int seen;
        int last_hs;
        bit rdy;
        bit prev_hold;
        logic [63:0] prev_do;
        @(negedge clk);
        sec_lvl = lvl;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("clear_rdy", {63'b0, bus.poly_ready_i}, 64'd0);
        @(negedge clk);
        check_eq("collect_rdy", {63'b0, bus.poly_ready_i}, 64'd1);
        beat   = 0;
        budget = 0;
        while (beat < k*64 && budget < 4000) begin
            bus.poly_valid_i = rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive_beat(beat);
            if (bus.poly_valid_i && bus.poly_ready_i) beat++;
            budget++;
            @(negedge clk);
        end
        bus.poly_valid_i = 1'b0;
        check_eq("beats", 64'(beat), 64'(k*64));
        check_eq("rdy_drop", {63'b0, bus.poly_ready_i}, 64'd0);
        if (exp_rej) begin
            check_eq("rej_done", {63'b0, done}, 64'd1);
            check_eq("rej_flag", {63'b0, reject}, 64'd1);
            check_eq("rej_novalid", {63'b0, bus.valid_o}, 64'd0);
            @(negedge clk);
            check_eq("rej_done_pulse", {63'b0, done}, 64'd0);
            check_eq("rej_novalid2", {63'b0, bus.valid_o}, 64'd0);
            return;
        end
        check_eq("first_valid", {63'b0, bus.valid_o}, 64'd1);
        seen      = 0;
        budget    = 0;
        last_hs   = -10;
        prev_hold = 1'b0;
        prev_do   = '0;
        while (!done && budget < 500) begin
            if (prev_hold) begin
                check_eq("hold_valid", {63'b0, bus.valid_o}, 64'd1);
                check_eq("hold_do", bus.do_o, prev_do);
            end
            rdy = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ready_o = rdy;
            if (bus.valid_o && rdy) begin
                if (exp_q.size() > 0)
                    check_eq($sformatf("word%0d", seen), bus.do_o, exp_q.pop_front());
                else
                    check_eq("extra_word", 64'(seen), 64'(nwords));
                seen++;
                last_hs = budget;
            end
            prev_hold = bus.valid_o && !rdy;
            prev_do   = bus.do_o;
            budget++;
            if (abort_after > 0 && seen == abort_after) break;
            @(negedge clk);
        end
        if (abort_after > 0) begin
            @(negedge clk);
            rst         = 1'b1;
            bus.ready_o = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            check_eq("abort_valid", {63'b0, bus.valid_o}, 64'd0);
            check_eq("abort_do", bus.do_o, 64'd0);
            check_eq("abort_rdy", {63'b0, bus.poly_ready_i}, 64'd0);
            check_eq("abort_done", {63'b0, done}, 64'd0);
            check_eq("abort_reject", {63'b0, reject}, 64'd0);
            check_eq("abort_state", {61'b0, state_dbg}, 64'd0);
            @(negedge clk);
            check_eq("abort_still_idle", {63'b0, bus.valid_o}, 64'd0);
            exp_q.delete();
            return;
        end
        bus.ready_o = 1'b0;
        check_eq("done_seen", {63'b0, done}, 64'd1);
        check_eq("done_after_last", 64'(budget - last_hs), 64'd1);
        check_eq("word_count", 64'(seen), 64'(nwords));
        check_eq("exp_empty", 64'(exp_q.size()), 64'd0);
        check_eq("reject_ok", {63'b0, reject}, 64'd0);
        check_eq("valid_off", {63'b0, bus.valid_o}, 64'd0);
        @(negedge clk);
        check_eq("done_pulse", {63'b0, done}, 64'd0);
        check_eq("back_idle", {61'b0, state_dbg}, 64'd0);
    endtask

    initial begin
        logic [63:0] w;
        rst              = 1'b1;
        start            = 1'b0;
        sec_lvl          = 3'd2;
        bus.poly_valid_i = 1'b0;
        bus.poly0_i      = '0;
        bus.poly1_i      = '0;
        bus.ready_o      = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_eq("rst_poly_ready", {63'b0, bus.poly_ready_i}, 64'd0);
        check_eq("rst_valid", {63'b0, bus.valid_o}, 64'd0);
        check_eq("rst_do", bus.do_o, 64'd0);
        check_eq("rst_done", {63'b0, done}, 64'd0);
        check_eq("rst_reject", {63'b0, reject}, 64'd0);
        check_eq("rst_state", {61'b0, state_dbg}, 64'd0);
        rst = 1'b0;

        // Level 2, no hints.
        clear_mem();
        push_zeros(11);
        run_encode(3'd2, 4, 11, 1'b0, 1'b0, 0);

        // Level 2, single hint at poly 0 coeff 5.
        clear_mem();
        r0_mem[5] = 24'd95233;
        exp_q.push_back(64'h0500000000000000);
        push_zeros(9);
        exp_q.push_back(64'h0101010100000000);
        run_encode(3'd2, 4, 11, 1'b0, 1'b0, 0);

        // Level 3, single hint at poly 5 coeff 255.
        clear_mem();
        r0_mem[5*256 + 255] = 24'd261889;
        exp_q.push_back(64'hFF00000000000000);
        push_zeros(6);
        exp_q.push_back(64'h0000000001000000);
        run_encode(3'd3, 6, 8, 1'b0, 1'b0, 0);

        // Level 2 boundary lanes at poly 0 coeffs 0..5.
        clear_mem();
        r0_mem[0] = 24'd95232;
        r0_mem[1] = 24'd95233;
        r0_mem[2] = 24'd8285184;
        r0_mem[3] = 24'd8285185;
        r1_mem[3] = 24'd0;
        r0_mem[4] = 24'd8285185;
        r1_mem[4] = 24'd3;
        r0_mem[5] = 24'd8285186;
`ifdef MAKEHINT_COMPUTE_EN
        exp_q.push_back(64'h0102040000000000);
`else
        exp_q.push_back(64'h0103040000000000);
`endif
        push_zeros(9);
        exp_q.push_back(64'h0303030300000000);
        run_encode(3'd2, 4, 11, 1'b0, 1'b0, 0);

        // Level 2, exactly 80 hints: slot bytes 0..79 then counts of 80.
        clear_mem();
        for (int c = 0; c < 80; c++) r0_mem[c] = 24'd95233;
        for (int j = 0; j < 10; j++) begin
            w = '0;
            for (int k = 0; k < 8; k++) w = {w[55:0], 8'(8*j + k)};
            exp_q.push_back(w);
        end
        exp_q.push_back(64'h5050505000000000);
        run_encode(3'd2, 4, 11, 1'b0, 1'b0, 0);

        // Level 2, 81 hints rejects.
        r0_mem[80] = 24'd95233;
        run_encode(3'd2, 4, 11, 1'b1, 1'b0, 0);

        // Level 5 with random stalls: abort mid-emit, then a full encode.
        clear_mem();
        r0_mem[2*256 + 3]   = 24'd261889;
        r0_mem[7*256 + 200] = 24'd261889;
        for (int pass = 0; pass < 2; pass++) begin
            exp_q.push_back(64'h03C8000000000000);
            push_zeros(8);
            exp_q.push_back(64'h0000000000010101);
            exp_q.push_back(64'h0101020000000000);
            run_encode(3'd5, 8, 11, 1'b0, 1'b1, (pass == 0) ? 4 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
